mem_ctrl: RTL
=============

Name: mem_ctrl

Overview:
- Byte-serial memory controller that shares the single 8-bit RAM port between instruction fetch (IF) and the load/store path fed by the execute stage (opcode/funct3/mem_addr/wdata).
- Arbitrates between the two requesters and sequences each 1/2/4-byte access as little-endian byte transfers.
- Returns sign- or zero-extended load data and asserts a busy/stall indication to the pipeline.

Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 32, width of the word-level data ports.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global run enable; 0 = pause
- if_req  in  1  fetch request; level, held until if_done
- if_addr  in  32  fetch address (always a 4-byte read)
- if_done  out  1  one-cycle pulse; if_rdata valid this cycle
- if_rdata  out  32  fetched instruction word
- ls_req  in  1  load/store request; level, held until ls_done
- ls_we  in  1  1 = store, 0 = load
- ls_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- ls_addr  in  32  byte address
- ls_wdata  in  32  store data; low bytes used
- ls_done  out  1  one-cycle pulse; ls_rdata valid this cycle
- ls_rdata  out  32  extended load result
- ram_a  out  32  RAM byte address
- ram_dout  out  8  RAM write byte
- ram_din  in  8  RAM read byte, valid the cycle after ram_a is presented with ram_wr=0
- ram_wr  out  1  RAM write strobe
- busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset values: all outputs 0, state IDLE, byte counter 0, latched request cleared.
- States: IDLE, READ, WRITE, DONE.
- N (bytes) = 1 for funct3[1:0]=00, 2 for 01, 4 for 10. IF always uses N=4. Unlisted funct3 values are treated as W.
- Arbitration (IDLE only): the controller samples requests at each edge.
  - ls_req has priority over if_req.
  - The winner's address, data, funct3 and we are latched.
  - Next state is WRITE if the winner is a store, otherwise READ.
  - A granted transaction is never preempted. The loser's req stays high and is served after DONE.
- READ, with request accepted at the edge ending cycle T:
  - Cycles T+1..T+N: ram_a = base+k for k=0..N-1, ram_wr=0.
  - Byte k is captured from ram_din at the edge ending cycle T+2+k, into bits [8k+7:8k].
  - State DONE in cycle T+N+2. Load latency is N+2 cycles (LW=6, LH=4, LB=3).
- WRITE, with request accepted at the edge ending cycle T:
  - Cycles T+1..T+N: ram_wr=1, ram_a = base+k, ram_dout = wdata[8k+7:8k].
  - State DONE in cycle T+N+1.
- DONE lasts exactly 1 cycle:
  - The matching if_done or ls_done is 1 for that cycle. rdata is valid for a READ.
  - Loads: B/H are sign-extended from bit 7/15; BU/HU are zero-extended.
  - rdata holds its value until the next done for that requester.
  - Requests are ignored in DONE; next state is IDLE.
  - Requesters deassert req at the edge ending the done cycle, or present the next request at that edge.
- Address arithmetic: base+k wraps modulo 2^32 (0xFFFFFFFF+1 = 0x00000000). No alignment check.
- ram_wr is 0 in every state except WRITE. ram_a and ram_dout hold their last value when idle.
- rdy=0:
  - All registers hold and ram_wr is forced 0.
  - If rdy drops in READ or WRITE, the byte counter resets to 0 and on rdy=1 the transfer restarts from byte 0 with the same latched request. Rewriting identical bytes is harmless.
  - In DONE, the done pulse is deferred until rdy=1, so it is never lost or duplicated.
  - In IDLE, no grant is made.
- rst=1 overrides everything, including mid-transaction. The in-flight access is dropped with no done pulse.

Test Plan:
- LW ls_addr=0x100, RAM[0x100..0x103]=11 22 33 44 -> ram_a 0x100..0x103 on T+1..T+4; ls_done at T+6; ls_rdata=0x44332211.
- LB then LBU at 0x200 where RAM=0x80 -> ls_rdata=0xFFFFFF80 then 0x00000080; each done at T+3.
- SH ls_addr=0x300, wdata=0xDEADBEEF -> ram_wr=1 on T+1 (a=0x300, dout=0xEF) and T+2 (a=0x301, dout=0xBE); ls_done at T+3; bytes 0x302/0x303 are not written.
- if_req and ls_req (LW) rise in the same cycle -> load served first (ls_done at T+6); IF accepted in the following IDLE cycle T+7, so if_done at T+13; busy stays high except in cycle T+7.
- LW at 0xFFFFFFFE -> ram_a sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- rdy=0 for 3 cycles starting in cycle T+3 of an LW -> no ram_wr, counter restarts; ram_a=base+0 on the first rdy=1 cycle; ls_done exactly once, with the correct word.
- rst asserted during WRITE -> ram_wr=0 and busy=0 the next cycle, no done pulse; a subsequent request completes normally.

Source files
------------

// File: rtl/mem_ctrl.sv
// Byte-serial controller sharing one 8-bit RAM port between instruction fetch and
// the load/store path; little-endian 1/2/4-byte accesses with load extension.
module mem_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [2:0]        ls_funct3,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_done,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic              ram_wr,
  output logic              busy
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  n_q;
  logic              is_if_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rbuf_q;
  logic [ADDR_W-1:0] ram_a_q;
  logic [7:0]        ram_dout_q;
  logic              wr_q;
  logic              if_done_q;
  logic              ls_done_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] ls_rdata_q;

  logic [CNT_W-1:0]  cnt_d;
  logic              more_d;
  logic [ADDR_W-1:0] addr_d;
  logic [1:0]        wr_idx_d;
  logic [1:0]        rd_idx_d;
  logic [7:0]        wbyte_d;
  logic [DATA_W-1:0] rbuf_d;

  function automatic logic [CNT_W-1:0] nbytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return CNT_W'(1);
      2'b01:   return CNT_W'(2);
      default: return CNT_W'(4);
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] w, input logic [2:0] f3);
    case (f3)
      3'b000:  return {{(DATA_W-8){w[7]}}, w[7:0]};
      3'b001:  return {{(DATA_W-16){w[15]}}, w[15:0]};
      3'b100:  return {{(DATA_W-8){1'b0}}, w[7:0]};
      3'b101:  return {{(DATA_W-16){1'b0}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  // Next byte address/data, and the read buffer with the byte arriving this cycle merged in
  always_comb begin
    cnt_d    = cnt_q + CNT_W'(1);
    more_d   = (cnt_d < n_q);
    addr_d   = base_q + ADDR_W'(cnt_d);
    wr_idx_d = cnt_d[1:0];
    wbyte_d  = wdata_q[{wr_idx_d, 3'b000} +: 8];
    rd_idx_d = 2'(cnt_q - CNT_W'(1));
    rbuf_d   = rbuf_q;
    rbuf_d[{rd_idx_d, 3'b000} +: 8] = ram_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      n_q        <= '0;
      is_if_q    <= 1'b0;
      f3_q       <= '0;
      base_q     <= '0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      ram_a_q    <= '0;
      ram_dout_q <= '0;
      wr_q       <= 1'b0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else if (!rdy) begin
      // Pause: an interrupted transfer is rewound so it restarts from byte 0
      if (state_q == S_READ || state_q == S_WRITE) begin
        cnt_q   <= '0;
        ram_a_q <= base_q;
      end
      if (state_q == S_WRITE) ram_dout_q <= wdata_q[7:0];
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ls_req) begin
            is_if_q <= 1'b0;
            base_q  <= ls_addr;
            ram_a_q <= ls_addr;
            f3_q    <= ls_funct3;
            n_q     <= nbytes(ls_funct3);
            wdata_q <= ls_wdata;
            cnt_q   <= '0;
            rbuf_q  <= '0;
            if (ls_we) begin
              state_q    <= S_WRITE;
              ram_dout_q <= ls_wdata[7:0];
              wr_q       <= 1'b1;
            end else begin
              state_q <= S_READ;
            end
          end else if (if_req) begin
            is_if_q <= 1'b1;
            base_q  <= if_addr;
            ram_a_q <= if_addr;
            f3_q    <= 3'b010;
            n_q     <= CNT_W'(4);
            cnt_q   <= '0;
            rbuf_q  <= '0;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          // cnt_q counts addresses issued; byte cnt_q-1 arrives on ram_din now
          if (cnt_q != '0) rbuf_q <= rbuf_d;
          if (cnt_q == n_q) begin
            state_q <= S_DONE;
            if (is_if_q) begin
              if_rdata_q <= rbuf_d;
              if_done_q  <= 1'b1;
            end else begin
              ls_rdata_q <= extend(rbuf_d, f3_q);
              ls_done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_d;
            if (more_d) ram_a_q <= addr_d;
          end
        end
        S_WRITE: begin
          if (more_d) begin
            cnt_q      <= cnt_d;
            ram_a_q    <= addr_d;
            ram_dout_q <= wbyte_d;
          end else begin
            wr_q      <= 1'b0;
            ls_done_q <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          if_done_q <= 1'b0;
          ls_done_q <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Strobes are masked by rdy so a paused DONE or WRITE cycle has no effect
  assign ram_wr   = wr_q & rdy;
  assign if_done  = if_done_q & rdy;
  assign ls_done  = ls_done_q & rdy;
  assign if_rdata = if_rdata_q;
  assign ls_rdata = ls_rdata_q;
  assign ram_a    = ram_a_q;
  assign ram_dout = ram_dout_q;
  assign busy     = (state_q != S_IDLE);

endmodule
